// File: rtl/cordic_pkg.sv
// ---------------------------------------------------------------------------
// cordic_pkg
//   Shared definitions for the CORDIC sweep sequencer: FSM state encoding,
//   degree range constants, Q2.14 / offset-binary reference values and a
//   step clamp helper.
// ---------------------------------------------------------------------------
package cordic_pkg;

  typedef enum logic [2:0] {
    ST_FLUSH,
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_CAPTURE,
    ST_PACE
  } state_t;

  localparam logic [9:0]  DEG_FULL = 10'd360;
  localparam logic [8:0]  DEG_MAX  = 9'd359;

  localparam logic [15:0] Q14_ONE  = 16'h4000;
  localparam logic [7:0]  U8_MID   = 8'h80;

  function automatic logic [8:0] clamp_deg(input logic [8:0] deg);
    return (deg > DEG_MAX) ? DEG_MAX : deg;
  endfunction

endpackage

// File: rtl/q14_to_u8_sat.sv
// ---------------------------------------------------------------------------
// q14_to_u8_sat
//   Combinational converter from a signed Q2.14 value to a saturated
//   unsigned 8-bit offset-binary sample (1.0 -> 255, 0 -> 128, -1.0 -> 0).
// Ports
//   q14  in   16  signed Q2.14 input
//   u8   out  8   offset-binary output, clipped to [0,255]
// ---------------------------------------------------------------------------
module q14_to_u8_sat
  import cordic_pkg::*;
(
  input  logic [15:0] q14,
  output logic [7:0]  u8
);

  // Full scale (Q14_ONE) lands U8_MID counts above mid-scale: shift by 14-7.
  localparam int SHIFT = $clog2(Q14_ONE) - $clog2(U8_MID);

  logic signed [15:0] t;

  always_comb begin
    t = ($signed(q14) >>> SHIFT) + $signed({8'h00, U8_MID});
    if (t < 16'sd0)
      u8 = 8'h00;
    else if (t > 16'sd255)
      u8 = 8'hFF;
    else
      u8 = t[7:0];
  end

endmodule

// File: rtl/cordic_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// cordic_sweep_ctrl
//   Steps a degree angle through 0..359, launches the sin/cos CORDIC core,
//   captures its result on a fresh done edge and presents both values as
//   saturated offset-binary bytes.
//   Optional build macro SWEEP_TIMEOUT_EN adds a WAIT-state watchdog that
//   sets a sticky timeout_err and retries the same angle after a flush.
// Ports
//   clk           in   1   clock
//   reset         in   1   asynchronous, active-high reset
//   enable        in   1   run the sweep (stop takes effect after the in-flight conversion)
//   step          in   9   degrees per sample, clamped to 359
//   cordic_start  out  1   one-cycle start pulse to the core
//   cordic_angle  out  16  angle to the core, degrees 0..359
//   cordic_sine   in   16  signed Q2.14 sine from the core
//   cordic_cosine in   16  signed Q2.14 cosine from the core
//   cordic_done   in   1   core done level
//   sin_u8        out  8   captured sine, offset-binary
//   cos_u8        out  8   captured cosine, offset-binary
//   sample_valid  out  1   one-cycle pulse when sin_u8/cos_u8 update
//   busy          out  1   high in every state except IDLE
//   timeout_err   out  1   sticky watchdog flag (0 without SWEEP_TIMEOUT_EN)
// ---------------------------------------------------------------------------
// state      | meaning
// FLUSH      | let the core drain after reset / timeout
// IDLE       | stopped, waiting for enable
// LAUNCH     | start pulse high for one cycle
// WAIT       | waiting for a fresh done (low seen, then high)
// CAPTURE    | outputs updated, angle advanced
// PACE       | spacing between capture and next launch
// ---------------------------------------------------------------------------
module cordic_sweep_ctrl
  import cordic_pkg::*;
#(
  parameter int PACE_DIV       = 16,
  parameter int FLUSH_CYCLES   = 40,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [8:0]  step,
  output logic        cordic_start,
  output logic [15:0] cordic_angle,
  input  logic [15:0] cordic_sine,
  input  logic [15:0] cordic_cosine,
  input  logic        cordic_done,
  output logic [7:0]  sin_u8,
  output logic [7:0]  cos_u8,
  output logic        sample_valid,
  output logic        busy,
  output logic        timeout_err
);

  state_t      state;
  logic [15:0] flush_cnt;
  logic [15:0] pace_cnt;
  logic [9:0]  angle;
  logic        seen_low;
  logic [7:0]  sin_conv;
  logic [7:0]  cos_conv;
  logic [9:0]  angle_sum;
  logic [9:0]  angle_next;

`ifdef SWEEP_TIMEOUT_EN
  logic [15:0] wd_cnt;
`endif

  q14_to_u8_sat u_sin_conv (.q14(cordic_sine),   .u8(sin_conv));
  q14_to_u8_sat u_cos_conv (.q14(cordic_cosine), .u8(cos_conv));

  // Both operands are below 360, so one conditional subtract wraps the sum.
  always_comb begin
    angle_sum  = angle + {1'b0, clamp_deg(step)};
    angle_next = (angle_sum >= DEG_FULL) ? (angle_sum - DEG_FULL) : angle_sum;
  end

  assign cordic_angle = {6'd0, angle};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_FLUSH;
      flush_cnt    <= 16'(FLUSH_CYCLES);
      pace_cnt     <= 16'd0;
      angle        <= 10'd0;
      seen_low     <= 1'b0;
      cordic_start <= 1'b0;
      sin_u8       <= U8_MID;
      cos_u8       <= U8_MID;
      sample_valid <= 1'b0;
      busy         <= 1'b1;
`ifdef SWEEP_TIMEOUT_EN
      wd_cnt       <= 16'd0;
      timeout_err  <= 1'b0;
`endif
    end else begin
      cordic_start <= 1'b0;
      sample_valid <= 1'b0;
      case (state)
        ST_FLUSH: begin
          if (flush_cnt == 16'd0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 16'd1;
          end
        end
        ST_IDLE: begin
          if (enable) begin
            state        <= ST_LAUNCH;
            cordic_start <= 1'b1;
            busy         <= 1'b1;
          end
        end
        ST_LAUNCH: begin
          seen_low <= 1'b0;
          state    <= ST_WAIT;
`ifdef SWEEP_TIMEOUT_EN
          wd_cnt   <= 16'(TIMEOUT_CYCLES - 1);
`endif
        end
        ST_WAIT: begin
          // A done still high from the previous conversion is ignored until
          // the core has dropped it at least once.
          if (cordic_done && seen_low) begin
            sin_u8       <= sin_conv;
            cos_u8       <= cos_conv;
            sample_valid <= 1'b1;
            state        <= ST_CAPTURE;
          end
`ifdef SWEEP_TIMEOUT_EN
          else if (wd_cnt == 16'd0) begin
            timeout_err <= 1'b1;
            flush_cnt   <= 16'(FLUSH_CYCLES);
            state       <= ST_FLUSH;
          end
`endif
          else begin
            if (!cordic_done)
              seen_low <= 1'b1;
`ifdef SWEEP_TIMEOUT_EN
            wd_cnt <= wd_cnt - 16'd1;
`endif
          end
        end
        ST_CAPTURE: begin
          angle <= angle_next;
          if (PACE_DIV == 0) begin
            if (enable) begin
              state        <= ST_LAUNCH;
              cordic_start <= 1'b1;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            pace_cnt <= 16'(PACE_DIV - 1);
            state    <= ST_PACE;
          end
        end
        ST_PACE: begin
          if (pace_cnt == 16'd0) begin
            if (enable) begin
              state        <= ST_LAUNCH;
              cordic_start <= 1'b1;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            pace_cnt <= pace_cnt - 16'd1;
          end
        end
        default: begin
          state     <= ST_FLUSH;
          flush_cnt <= 16'(FLUSH_CYCLES);
          busy      <= 1'b1;
        end
      endcase
    end
  end

`ifndef SWEEP_TIMEOUT_EN
  assign timeout_err = 1'b0;
`endif

endmodule
